// File: rtl/arm7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm7_pkg
// Description : Shared types and constants for the ARM7 front end: word
//               width, PC increment, fetch FSM states and the prefetch
//               queue entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package arm7_pkg;

  localparam int unsigned       WORD_W  = 32;
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

  // IDLE: nothing outstanding; WAIT: fetch outstanding, data wanted;
  // DROP: fetch outstanding, data to be discarded (redirected meanwhile).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular prefetch buffer between instruction memory and
//               decode. Push and pop may occur together in any state,
//               including full; flush empties the buffer and wins over both.
// Ports       : clk, reset     - clock, asynchronous active-high reset
//               push_i/entry_i - write one fetched entry at the tail
//               pop_i          - retire the head entry
//               flush_i        - discard all contents
//               head_o         - head entry (storage word at read pointer)
//               empty_o        - no entries held
//               count_o        - number of entries held (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import arm7_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  fetch_entry_t                 entry_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output fetch_entry_t                 head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      count_d = count_q + 1'b1;
      else if (!push_i && pop_i) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : ARM7 fetch stage. Issues word fetches at the architectural
//               PC, advances the PC in the register file, buffers returned
//               words in a prefetch queue for decode, and redirects on a
//               taken branch from execute.
// Ports       : clk, reset                  - clock, async active-high reset
//               pc / pc_update / pc_write   - register-file PC read/write
//               imem_req/addr/ack/rdata     - instruction memory handshake
//               branch_taken/branch_target  - redirect from execute
//               instr/instr_pc/instr_valid/instr_ready - decode handshake
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
  import arm7_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_update,
  output logic              pc_write,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic              req_q;
  logic [WORD_W-1:0] addr_q;

  fetch_entry_t      q_head;
  fetch_entry_t      q_entry;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;

  logic              do_pop;
  logic              do_push;
  logic              do_issue;
  logic              room;

  assign do_pop = instr_valid & instr_ready;

  // An outstanding WAIT fetch already owns a slot, so a new fetch is only
  // issued when the queue can absorb it on top of everything in flight.
  assign room = (32'(q_count) + 32'(state_q == WAIT) - 32'(do_pop)) < DEPTH;

  assign do_issue = !branch_taken && room &&
                    ((state_q == IDLE) || ((state_q == WAIT) && imem_ack));

  assign do_push  = (state_q == WAIT) && imem_ack && !branch_taken;

  assign pc_write  = !reset && (branch_taken || do_issue);
  assign pc_update = branch_taken ? branch_target : pc + PC_STEP;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (do_issue) state_d = WAIT;
      end
      WAIT: begin
        if (branch_taken)  state_d = imem_ack ? IDLE : DROP;
        else if (imem_ack) state_d = do_issue ? WAIT : IDLE;
      end
      DROP: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d != IDLE);
      if (do_issue) addr_q <= pc;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  assign q_entry = '{instr: imem_rdata, pc: addr_q};

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (do_push),
    .entry_i (q_entry),
    .pop_i   (do_pop && !branch_taken),
    .flush_i (branch_taken),
    .head_o  (q_head),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign instr_valid = !q_empty;
  assign instr       = q_head.instr;
  assign instr_pc    = q_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch with a register-
//               file PC model, a variable-latency instruction memory and a
//               scoreboard of expected decode entries and fetch addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic [31:0] pc_update;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          lat = 0;
  int          cyc = 0;
  logic        stray_ack = 1'b0;
  logic        pc_load = 1'b1;
  logic [31:0] pc_load_val = '0;

  logic [63:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] upd_log[$];
  logic [31:0] ipc_log[$];
  int          ipc_cyc[$];

  logic        kill = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;

  instruction_fetch #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .pc_update     (pc_update),
    .pc_write      (pc_write),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file PC: loaded by the bench, otherwise written by the DUT.
  always @(posedge clk) begin
    if (pc_load)       pc <= pc_load_val;
    else if (pc_write) pc <= pc_update;
  end

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h3C5A};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Instruction memory: acks after 'lat' idle cycles of a request.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || !imem_req) begin
        wcnt       = 0;
        imem_ack   = stray_ack;
        imem_rdata = 32'hDEAD_BEEF;
      end else if (wcnt >= lat) begin
        wcnt       = 0;
        imem_ack   = 1'b1;
        imem_rdata = memdata(imem_addr);
      end else begin
        wcnt       = wcnt + 1;
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic        new_req;
    logic [63:0] e;
    if (reset) begin
      exp_q.delete();
      addr_q.delete();
      kill      = 1'b0;
      prev_req  = 1'b0;
      prev_ack  = 1'b0;
      prev_addr = '0;
    end else begin
      new_req = imem_req && (!prev_req || prev_ack);
      if (new_req) begin
        chk("issue_pending", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) chk("imem_addr", imem_addr, addr_q.pop_front());
      end else if (imem_req) begin
        chk("addr_hold", imem_addr, prev_addr);
      end

      if (branch_taken) begin
        chk("br_pc_write", pc_write, 1);
        chk("br_pc_update", pc_update, branch_target);
        exp_q.delete();
        addr_q.delete();
        if (imem_req) kill = !imem_ack;
      end else begin
        if (instr_valid && instr_ready) begin
          chk("sb_has_entry", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("instr", instr, e[63:32]);
            chk("instr_pc", instr_pc, e[31:0]);
          end
          ipc_log.push_back(instr_pc);
          ipc_cyc.push_back(cyc);
        end
        if (imem_req && imem_ack) begin
          if (kill) begin
            chk("drop_no_issue", pc_write, 0);
            kill = 1'b0;
          end else begin
            exp_q.push_back({memdata(imem_addr), imem_addr});
          end
        end else if (imem_req) begin
          chk("hold_no_issue", pc_write, 0);
        end
        if (pc_write) begin
          chk("pc_step", pc_update, pc + 32'd4);
          addr_q.push_back(pc);
          upd_log.push_back(pc_update);
        end
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  end

  task automatic apply_reset(input logic [31:0] start_pc);
    @(posedge clk);
    #3;
    reset        = 1'b1;
    branch_taken = 1'b0;
    pc_load      = 1'b1;
    pc_load_val  = start_pc;
    repeat (2) @(posedge clk);
    #3;
    reset   = 1'b0;
    pc_load = 1'b0;
    upd_log.delete();
    ipc_log.delete();
    ipc_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic        ok;
    logic        seen_low;
    logic        found;
    logic [31:0] kaddr;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_pc_write", pc_write, 0);

    // Straight-line fetch, zero-wait memory
    lat = 0;
    instr_ready = 1'b1;
    apply_reset(32'h0);
    repeat (8) @(posedge clk);
    #1;
    chk("sl_upd_cnt", upd_log.size() >= 3, 1);
    if (upd_log.size() >= 3) begin
      chk("sl_upd0", upd_log[0], 32'h4);
      chk("sl_upd1", upd_log[1], 32'h8);
      chk("sl_upd2", upd_log[2], 32'hC);
    end
    chk("sl_ipc_cnt", ipc_log.size() >= 3, 1);
    if (ipc_log.size() >= 3) begin
      chk("sl_ipc0", ipc_log[0], 32'h0);
      chk("sl_ipc1", ipc_log[1], 32'h4);
      chk("sl_ipc2", ipc_log[2], 32'h8);
      chk("sl_ipc_gap", ipc_cyc[2] - ipc_cyc[0], 2);
    end

    // Backpressure: queue fills, fetching stops, then resumes at 0x8
    instr_ready = 1'b0;
    lat = 0;
    apply_reset(32'h0);
    repeat (6) @(posedge clk);
    #4;
    chk("bp_req_low", imem_req, 0);
    chk("bp_pc_hold", pc, 32'h8);
    chk("bp_valid", instr_valid, 1);
    chk("bp_issues", upd_log.size(), 2);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_resume", ok, 1);
    chk("bp_resume_addr", imem_addr, 32'h8);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_ipc_cnt", ipc_log.size() >= 4, 1);
    if (ipc_log.size() >= 4) begin
      chk("bp_ipc0", ipc_log[0], 32'h0);
      chk("bp_ipc1", ipc_log[1], 32'h4);
      chk("bp_ipc2", ipc_log[2], 32'h8);
      chk("bp_ipc3", ipc_log[3], 32'hC);
    end

    // Branch while a fetch waits on slow memory
    instr_ready = 1'b0;
    lat = 3;
    apply_reset(32'h0);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bw_first_word", ok, 1);
    @(posedge clk);
    #1;
    branch_target = 32'h100;
    branch_taken  = 1'b1;
    @(negedge clk);
    chk("bw_pc_write", pc_write, 1);
    chk("bw_pc_update", pc_update, 32'h100);
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    ipc_log.delete();
    @(negedge clk);
    chk("bw_valid_drop", instr_valid, 0);
    chk("bw_drop_req", imem_req, 1);
    ok = 1'b0;
    seen_low = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!imem_req) seen_low = 1'b1;
      else if (seen_low) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bw_next_req", ok, 1);
    chk("bw_next_addr", imem_addr, 32'h100);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("bw_ipc_cnt", ipc_log.size() >= 1, 1);
    if (ipc_log.size() >= 1) chk("bw_first_ipc", ipc_log[0], 32'h100);

    // Branch in the same cycle as an ack
    instr_ready = 1'b1;
    lat = 2;
    apply_reset(32'h0);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #2;
      if (imem_req && imem_ack) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bc_ack_seen", ok, 1);
    kaddr         = imem_addr;
    branch_target = 32'h200;
    branch_taken  = 1'b1;
    ipc_log.delete();
    @(negedge clk);
    chk("bc_pc_update", pc_update, 32'h200);
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    @(negedge clk);
    chk("bc_valid", instr_valid, 0);
    chk("bc_reissue", pc_write, 1);
    chk("bc_reissue_pc", pc, 32'h200);
    repeat (12) @(posedge clk);
    #1;
    found = 1'b0;
    foreach (ipc_log[j]) if (ipc_log[j] == kaddr) found = 1'b1;
    chk("bc_dropped", found, 0);
    chk("bc_ipc_cnt", ipc_log.size() >= 1, 1);
    if (ipc_log.size() >= 1) chk("bc_first_ipc", ipc_log[0], 32'h200);

    // Reset in the middle of a fetch, then a stray ack after release
    instr_ready = 1'b0;
    lat = 1;
    apply_reset(32'h0);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (instr_valid && imem_req) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rm_busy", ok, 1);
    @(posedge clk);
    #3;
    reset       = 1'b1;
    pc_load     = 1'b1;
    pc_load_val = 32'h40;
    #1;
    chk("rm_req", imem_req, 0);
    chk("rm_valid", instr_valid, 0);
    chk("rm_addr", imem_addr, 0);
    chk("rm_pc_write", pc_write, 0);
    stray_ack = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    reset   = 1'b0;
    pc_load = 1'b0;
    #1;
    stray_ack = 1'b0;
    @(negedge clk);
    chk("rm_restart_write", pc_write, 1);
    @(negedge clk);
    chk("rm_stray_ignored", instr_valid, 0);
    chk("rm_restart_req", imem_req, 1);
    chk("rm_restart_addr", imem_addr, 32'h40);

    // PC wrap-around
    instr_ready = 1'b1;
    lat = 0;
    apply_reset(32'hFFFF_FFFC);
    @(negedge clk);
    chk("wr_pc_write", pc_write, 1);
    chk("wr_pc_update", pc_update, 32'h0);
    @(negedge clk);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the ARM7 core, directly upstream of `register_file`'s program-counter port.
- Reads the architectural `pc` from `register_file`.
- Issues word fetches to instruction memory over a req/ack handshake.
- Advances the PC by writing `pc_update`/`pc_write` back to `register_file`.
- Buffers fetched words in a small prefetch queue that feeds decode over a valid/ready handshake.
- Execute redirects the stream on a taken branch by flushing the queue and discarding any in-flight fetch.

## Interface
Parameters:
- `DEPTH`, default 2: prefetch queue entries; allowed range ≥ 1.

Ports:
- `clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  asynchronous, active-high reset.
- `pc`  in  32  current PC from `register_file`.
- `pc_update`  out  32  next PC value, driven to `register_file`.
- `pc_write`  out  1  one-cycle PC write strobe to `register_file`.
- `imem_req`  out  1  fetch request; held high until acked.
- `imem_addr`  out  32  fetch address; stable while `imem_req` is high.
- `imem_ack`  in  1  memory response valid this cycle.
- `imem_rdata`  in  32  fetched word, valid with `imem_ack`.
- `branch_taken`  in  1  redirect strobe from execute.
- `branch_target`  in  32  redirect address.
- `instr`  out  32  head-of-queue instruction word.
- `instr_pc`  out  32  address of `instr`.
- `instr_valid`  out  1  queue non-empty.
- `instr_ready`  in  1  decode accepts the head entry this cycle.

## Operation
- **FSM states:**
  - IDLE: no fetch outstanding.
  - WAIT: fetch outstanding, data wanted.
  - DROP: fetch outstanding, data to be discarded.
- **Signal definitions:**
  - pop = `instr_valid` & `instr_ready`.
  - room = (count + (state==WAIT)) − pop < DEPTH.
- **Issue:**
  - Condition: !`branch_taken` & room & (state==IDLE | (state==WAIT & `imem_ack`)).
  - On issue:
    - `pc_write`=1 and `pc_update`=`pc`+4, modulo 2^32.
    - `imem_addr` <= `pc` at the edge.
    - Next state is WAIT.
- **WAIT, no ack:** hold. `imem_req`=1 with an unchanged `imem_addr`.
- **WAIT with ack, no branch:**
  - Push {`imem_rdata`, `imem_addr`} into the queue.
  - Next state is WAIT if issuing, else IDLE.
- **DROP with ack:** discard the data; go to IDLE. No issue happens in this cycle.
- **Branch (`branch_taken`=1), which overrides everything:**
  - `pc_write`=1, `pc_update`=`branch_target`.
  - The queue is cleared at the edge; any pop that cycle is ignored.
  - No push and no issue.
  - Next state by current state and ack:
    - IDLE → IDLE.
    - WAIT with ack → IDLE; the acked data is dropped.
    - WAIT without ack → DROP.
    - DROP with ack → IDLE.
    - DROP without ack → DROP.
- **Queue:**
  - Circular buffer with wrapping read/write pointers, plus a count from 0 to DEPTH.
  - Simultaneous push and pop is legal in any state, including full.
  - Overflow cannot occur, because room reserves a slot for every in-flight fetch.
- **`imem_req`** = (state==WAIT | state==DROP), taken from a registered state.
- **`pc_write`/`pc_update`** are combinational. `pc_write` is forced to 0 while `reset` is high.

## Timing
- **Reset values:**
  - state IDLE; queue empty.
  - `imem_req`=0, `imem_addr`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0.
  - `pc_write`=0; `pc_update` is don't-care.
- **Reset mid-operation:**
  - Any outstanding fetch is abandoned and `imem_req` falls immediately.
  - A late `imem_ack` arriving after reset is ignored, since state is IDLE.
- **Latency:**
  - Issue decided in cycle t.
  - `imem_req` high in t+1.
  - With ack in t+1, `instr_valid` rises in t+2.
- **Throughput:** with zero-wait memory and `instr_ready`=1, one instruction per cycle in steady state.
- **Register-file timing:** `register_file` updates `pc` on the edge ending the `pc_write` cycle, so `pc` is current at the next IDLE/WAIT decision.
- **Branch timing:** the first fetch after a branch in cycle t issues in cycle t+1 with address `branch_target`, unless a DROP is pending.

## Structure
- Shared package `arm7_pkg`:
  - `WORD_W`=32, `PC_STEP`=4.
  - Fetch state enum {IDLE, WAIT, DROP}.
  - Struct for a fetch entry {instr, pc}.
- Sub-module `fetch_queue`:
  - Parameterised DEPTH, push/pop/flush, count.
  - Exposes head data and the empty flag.
- The top level holds the FSM and the issue/room logic.

## Test plan
- **Straight-line fetch:** reset, `pc`=0, memory acks in the same cycle as req, `instr_ready`=1.
  - `pc_update` sequence is 0x4, 0x8, 0xC.
  - `instr_pc` shows 0x0, 0x4, 0x8 on consecutive cycles, each with its matching `imem_rdata`.
- **Backpressure:** `instr_ready`=0, DEPTH=2.
  - After 2 fetches, `imem_req` goes low and `pc` holds at 0x8.
  - Raising `instr_ready` resumes fetching at 0x8 with no lost or duplicated entries.
- **Branch while a fetch waits:** ack delayed 3 cycles, `branch_taken` with target 0x100.
  - `pc_update`=0x100 and `instr_valid` drops next cycle.
  - The late data is discarded.
  - The next `imem_addr` is 0x100.
- **Branch coincident with ack:** the acked word never appears on `instr`; the next fetch is from `branch_target`.
- **Reset mid-fetch:** `reset` asserted while WAIT.
  - `imem_req` and `instr_valid` fall immediately.
  - After release, fetch restarts from the `pc` value.
- **Wrap-around:** `pc`=0xFFFFFFFC yields `pc_update`=0x00000000.
